// File: rtl/stall_forward_unit_if.sv
// Hazard-unit signal bundle: pipeline stage register fields in, stall/flush
// controls and forwarding selects out.
interface stall_forward_unit_if;
    logic [4:0] Rs_D;
    logic [4:0] Rt_D;
    logic [4:0] Rs_E;
    logic [4:0] Rt_E;
    logic [4:0] Rt_M;
    logic [4:0] Dst_E;
    logic [4:0] Dst_M;
    logic [4:0] Dst_W;
    logic       RegWrite_E;
    logic       RegWrite_M;
    logic       RegWrite_W;
    logic       MemRead_M;
    logic [1:0] Tnew_E;
    logic [1:0] Tnew_M;
    logic [1:0] Tuse_Rs_D;
    logic [1:0] Tuse_Rt_D;

    logic       En_PC;
    logic       En_D;
    logic       Reset_E;
    logic [1:0] MuxForward_Rs_D;
    logic [1:0] MuxForward_Rt_D;
    logic [1:0] MuxForward_Rs_E;
    logic [1:0] MuxForward_Rt_E;
    logic       MuxForward_Rt_M;

    modport master (
        output Rs_D, Rt_D, Rs_E, Rt_E, Rt_M, Dst_E, Dst_M, Dst_W,
               RegWrite_E, RegWrite_M, RegWrite_W, MemRead_M,
               Tnew_E, Tnew_M, Tuse_Rs_D, Tuse_Rt_D,
        input  En_PC, En_D, Reset_E, MuxForward_Rs_D, MuxForward_Rt_D,
               MuxForward_Rs_E, MuxForward_Rt_E, MuxForward_Rt_M
    );

    modport slave (
        input  Rs_D, Rt_D, Rs_E, Rt_E, Rt_M, Dst_E, Dst_M, Dst_W,
               RegWrite_E, RegWrite_M, RegWrite_W, MemRead_M,
               Tnew_E, Tnew_M, Tuse_Rs_D, Tuse_Rt_D,
        output En_PC, En_D, Reset_E, MuxForward_Rs_D, MuxForward_Rt_D,
               MuxForward_Rs_E, MuxForward_Rt_E, MuxForward_Rt_M
    );
endinterface

// File: rtl/stall_forward_unit.sv
// Tuse/Tnew hazard unit for the 5-stage pipeline: stall/flush, forwarding selects
// and a saturating stall counter. Define FWD_W_TO_D_EN to enable the W->D bypass.
module stall_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    stall_forward_unit_if.slave hz,
    output logic [CNT_W-1:0] stall_cnt
);

`ifdef FWD_W_TO_D_EN
    localparam bit W_TO_D = 1'b1;
`else
    localparam bit W_TO_D = 1'b0;
`endif

    function automatic logic match(input logic [4:0] src, input logic wr, input logic [4:0] dst);
        return (src != 5'd0) && wr && (dst == src);
    endfunction

    function automatic logic stall_op(input logic [1:0] tuse, input logic m_e, input logic m_m,
                                      input logic [1:0] tnew_e, input logic [1:0] tnew_m,
                                      input logic mem_rd);
        // a load in M is never ready early, whatever Tnew_M claims
        return (tuse != 2'd3) &&
               ((m_e && (tnew_e > tuse)) || (m_m && (mem_rd || (tnew_m > tuse))));
    endfunction

    function automatic logic [1:0] fwd_d(input logic m_e, input logic m_m, input logic m_w,
                                         input logic e_rdy, input logic m_rdy);
        if (m_e && e_rdy)
            return 2'd1;
        else if (m_m && m_rdy)
            return 2'd2;
        else if (m_w && W_TO_D)
            return 2'd3;
        else
            return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic m_m, input logic m_w, input logic m_rdy);
        if (m_m && m_rdy)
            return 2'd1;
        else if (m_w)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    logic       rs_d_e, rs_d_m, rs_d_w;
    logic       rt_d_e, rt_d_m, rt_d_w;
    logic       rs_e_m, rs_e_w, rt_e_m, rt_e_w;
    logic       rt_m_w;
    logic       e_rdy, m_rdy;
    logic       stall;
    logic [1:0] sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e;

    always_comb begin
        rs_d_e = match(hz.Rs_D, hz.RegWrite_E, hz.Dst_E);
        rs_d_m = match(hz.Rs_D, hz.RegWrite_M, hz.Dst_M);
        rs_d_w = match(hz.Rs_D, hz.RegWrite_W, hz.Dst_W);
        rt_d_e = match(hz.Rt_D, hz.RegWrite_E, hz.Dst_E);
        rt_d_m = match(hz.Rt_D, hz.RegWrite_M, hz.Dst_M);
        rt_d_w = match(hz.Rt_D, hz.RegWrite_W, hz.Dst_W);
        rs_e_m = match(hz.Rs_E, hz.RegWrite_M, hz.Dst_M);
        rs_e_w = match(hz.Rs_E, hz.RegWrite_W, hz.Dst_W);
        rt_e_m = match(hz.Rt_E, hz.RegWrite_M, hz.Dst_M);
        rt_e_w = match(hz.Rt_E, hz.RegWrite_W, hz.Dst_W);
        rt_m_w = match(hz.Rt_M, hz.RegWrite_W, hz.Dst_W);
        e_rdy  = (hz.Tnew_E == 2'd0);
        m_rdy  = (hz.Tnew_M == 2'd0) && !hz.MemRead_M;
    end

    always_comb begin
        stall = stall_op(hz.Tuse_Rs_D, rs_d_e, rs_d_m, hz.Tnew_E, hz.Tnew_M, hz.MemRead_M) ||
                stall_op(hz.Tuse_Rt_D, rt_d_e, rt_d_m, hz.Tnew_E, hz.Tnew_M, hz.MemRead_M);
        sel_rs_d = fwd_d(rs_d_e, rs_d_m, rs_d_w, e_rdy, m_rdy);
        sel_rt_d = fwd_d(rt_d_e, rt_d_m, rt_d_w, e_rdy, m_rdy);
        sel_rs_e = fwd_e(rs_e_m, rs_e_w, m_rdy);
        sel_rt_e = fwd_e(rt_e_m, rt_e_w, m_rdy);
    end

    // reset holds the fetch side running while ID/EX keeps loading bubbles
    always_comb begin
        hz.En_PC           = 1'b1;
        hz.En_D            = 1'b1;
        hz.Reset_E         = 1'b1;
        hz.MuxForward_Rs_D = 2'd0;
        hz.MuxForward_Rt_D = 2'd0;
        hz.MuxForward_Rs_E = 2'd0;
        hz.MuxForward_Rt_E = 2'd0;
        hz.MuxForward_Rt_M = 1'b0;
        if (reset) begin
            hz.En_PC           = !stall;
            hz.En_D            = !stall;
            hz.Reset_E         = stall;
            hz.MuxForward_Rs_D = sel_rs_d;
            hz.MuxForward_Rt_D = sel_rt_d;
            hz.MuxForward_Rs_E = sel_rs_e;
            hz.MuxForward_Rt_E = sel_rt_e;
            hz.MuxForward_Rt_M = rt_m_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_stall_forward_unit.sv
// Directed bench for stall_forward_unit: expected controls queued per step,
// popped and compared once the combinational outputs settle.
module tb_stall_forward_unit;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef FWD_W_TO_D_EN
    localparam logic [1:0] W_ONLY_SEL = 2'd3;
`else
    localparam logic [1:0] W_ONLY_SEL = 2'd0;
`endif

    typedef struct {
        logic       rst;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, rt_m, dst_e, dst_m, dst_w;
        logic       rw_e, rw_m, rw_w, mem_rd;
        logic [1:0] tnew_e, tnew_m, tuse_rs, tuse_rt;
    } stim_t;

    typedef struct {
        logic       en_pc, en_d, reset_e;
        logic [1:0] rs_d, rt_d, rs_e, rt_e;
        logic       rt_m;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] exp_cnt;
    logic             model_stall;
    int               n_assert;
    int               n_fail;
    exp_t             exp_q[$];

    stall_forward_unit_if hz();

    stall_forward_unit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .hz        (hz),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset)
            exp_cnt <= '0;
        else if (model_stall && exp_cnt != CNT_MAX)
            exp_cnt <= exp_cnt + 1'b1;
    end

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b1, rs_d: 5'd0, rt_d: 5'd0, rs_e: 5'd0, rt_e: 5'd0, rt_m: 5'd0,
              dst_e: 5'd0, dst_m: 5'd0, dst_w: 5'd0, rw_e: 1'b0, rw_m: 1'b0, rw_w: 1'b0,
              mem_rd: 1'b0, tnew_e: 2'd0, tnew_m: 2'd0, tuse_rs: 2'd3, tuse_rt: 2'd3};
        return s;
    endfunction

    function automatic exp_t run_exp();
        exp_t e;
        e = '{en_pc: 1'b1, en_d: 1'b1, reset_e: 1'b0, rs_d: 2'd0, rt_d: 2'd0,
              rs_e: 2'd0, rt_e: 2'd0, rt_m: 1'b0};
        return e;
    endfunction

    function automatic exp_t stall_exp();
        exp_t e;
        e = run_exp();
        e.en_pc = 1'b0;
        e.en_d = 1'b0;
        e.reset_e = 1'b1;
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = run_exp();
        e.reset_e = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic drive(input stim_t s);
        reset         = s.rst;
        hz.Rs_D       = s.rs_d;
        hz.Rt_D       = s.rt_d;
        hz.Rs_E       = s.rs_e;
        hz.Rt_E       = s.rt_e;
        hz.Rt_M       = s.rt_m;
        hz.Dst_E      = s.dst_e;
        hz.Dst_M      = s.dst_m;
        hz.Dst_W      = s.dst_w;
        hz.RegWrite_E = s.rw_e;
        hz.RegWrite_M = s.rw_m;
        hz.RegWrite_W = s.rw_w;
        hz.MemRead_M  = s.mem_rd;
        hz.Tnew_E     = s.tnew_e;
        hz.Tnew_M     = s.tnew_m;
        hz.Tuse_Rs_D  = s.tuse_rs;
        hz.Tuse_Rt_D  = s.tuse_rt;
    endtask

    task automatic step(input string tag, input stim_t s, input exp_t e);
        exp_t got;
        @(negedge clk);
        drive(s);
        model_stall = s.rst && !e.en_pc;
        exp_q.push_back(e);
        #1;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            got = exp_q.pop_front();
            chk({tag, ".En_PC"},   16'(hz.En_PC),           16'(got.en_pc));
            chk({tag, ".En_D"},    16'(hz.En_D),            16'(got.en_d));
            chk({tag, ".Reset_E"}, 16'(hz.Reset_E),         16'(got.reset_e));
            chk({tag, ".Fwd_Rs_D"}, 16'(hz.MuxForward_Rs_D), 16'(got.rs_d));
            chk({tag, ".Fwd_Rt_D"}, 16'(hz.MuxForward_Rt_D), 16'(got.rt_d));
            chk({tag, ".Fwd_Rs_E"}, 16'(hz.MuxForward_Rs_E), 16'(got.rs_e));
            chk({tag, ".Fwd_Rt_E"}, 16'(hz.MuxForward_Rt_E), 16'(got.rt_e));
            chk({tag, ".Fwd_Rt_M"}, 16'(hz.MuxForward_Rt_M), 16'(got.rt_m));
            chk({tag, ".stall_cnt"}, 16'(stall_cnt),         16'(exp_cnt));
        end
    endtask

    initial begin
        stim_t s;
        stim_t t1;
        exp_t  e;
        n_assert    = 0;
        n_fail      = 0;
        exp_cnt     = '0;
        model_stall = 1'b0;
        drive(idle());
        reset = 1'b0;

        // RAW on rs from E with result one cycle out: stall inputs
        t1 = idle();
        t1.rs_d = 5'd5; t1.tuse_rs = 2'd0; t1.dst_e = 5'd5; t1.rw_e = 1'b1; t1.tnew_e = 2'd1;

        s = t1; s.rst = 1'b0;
        step("reset_hold", s, reset_exp());
        step("e_raw_stall", t1, stall_exp());
        step("cnt_after_stall", idle(), run_exp());
        chk("cnt_is_one", 16'(stall_cnt), 16'd1);

        s = idle(); s.rt_d = 5'd8; s.tuse_rt = 2'd1; s.dst_m = 5'd8; s.rw_m = 1'b1;
        s.mem_rd = 1'b1; s.tnew_m = 2'd1;
        step("load_use", s, stall_exp());
        s.mem_rd = 1'b0; s.tnew_m = 2'd0;
        e = run_exp(); e.rt_d = 2'd2;
        step("m_fwd_rt_d", s, e);

        s = idle(); s.rs_e = 5'd3; s.dst_m = 5'd3; s.dst_w = 5'd3; s.rw_m = 1'b1;
        s.rw_w = 1'b1; s.tnew_m = 2'd0;
        e = run_exp(); e.rs_e = 2'd1;
        step("rs_e_m_over_w", s, e);
        s.rw_m = 1'b0;
        e = run_exp(); e.rs_e = 2'd2;
        step("rs_e_w_only", s, e);

        s = idle(); s.dst_e = 5'd0; s.rw_e = 1'b1; s.rs_d = 5'd0; s.tnew_e = 2'd2; s.tuse_rs = 2'd0;
        step("reg0_no_match", s, run_exp());

        s = idle(); s.rt_m = 5'd9; s.dst_w = 5'd9; s.rw_w = 1'b1;
        e = run_exp(); e.rt_m = 1'b1;
        step("rt_m_from_w", s, e);

        s = idle(); s.rs_d = 5'd7; s.tuse_rs = 2'd0; s.dst_w = 5'd7; s.rw_w = 1'b1;
        e = run_exp(); e.rs_d = W_ONLY_SEL;
        step("d_match_w_only", s, e);

        s = idle(); s.rs_d = 5'd4; s.tuse_rs = 2'd1; s.dst_e = 5'd4; s.rw_e = 1'b1;
        s.tnew_e = 2'd0; s.dst_m = 5'd4; s.rw_m = 1'b1; s.tnew_m = 2'd0;
        e = run_exp(); e.rs_d = 2'd1;
        step("d_e_over_m", s, e);

        s = idle(); s.rs_d = 5'd6; s.tuse_rs = 2'd2; s.dst_e = 5'd6; s.rw_e = 1'b1; s.tnew_e = 2'd2;
        step("tnew_eq_tuse", s, run_exp());
        s.tuse_rs = 2'd1;
        step("tnew_gt_tuse", s, stall_exp());
        s.tuse_rs = 2'd3;
        step("tuse_unused", s, run_exp());

        s = idle(); s.rs_e = 5'd11; s.dst_m = 5'd11; s.rw_m = 1'b1; s.mem_rd = 1'b1;
        s.dst_w = 5'd11; s.rw_w = 1'b1;
        s.rt_e = 5'd12;
        e = run_exp(); e.rs_e = 2'd2;
        step("e_load_in_m_uses_w", s, e);

        s = idle(); s.rt_d = 5'd10; s.tuse_rt = 2'd0; s.dst_e = 5'd10; s.rw_e = 1'b1;
        s.tnew_e = 2'd0; s.rt_e = 5'd12; s.dst_m = 5'd12; s.rw_m = 1'b1; s.tnew_m = 2'd0;
        e = run_exp(); e.rt_d = 2'd1; e.rt_e = 2'd1;
        step("rt_d_e_rt_e_m", s, e);

        step("sat_start", t1, stall_exp());
        repeat ((1 << CNT_W) + 3) @(posedge clk);
        step("sat_hold", t1, stall_exp());
        chk("cnt_saturated", 16'(stall_cnt), 16'(CNT_MAX));

        s = idle(); s.rt_m = 5'd9; s.dst_w = 5'd9; s.rw_w = 1'b1; s.rst = 1'b0;
        step("reset_mid", s, reset_exp());
        step("after_reset", idle(), run_exp());
        chk("cnt_cleared", 16'(stall_cnt), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
